// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Desc     : Control, instruction-memory and IF/ID bundle of the fetch stage.
//            FETCH_PERF_EN adds the performance-counter outputs.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    // Fetch-stage side
    modport master (
        input  stall,
        input  redirect,
        input  redirect_target,
        input  imem_data,
        output imem_addr,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_plus4,
        output ifid_valid,
`ifdef FETCH_PERF_EN
        output perf_fetch_cnt,
        output perf_stall_cnt,
`endif
        output fetch_fault
    );

    // Pipeline / memory side
    modport slave (
        output stall,
        output redirect,
        output redirect_target,
        output imem_data,
        input  imem_addr,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  ifid_valid,
`ifdef FETCH_PERF_EN
        input  perf_fetch_cnt,
        input  perf_stall_cnt,
`endif
        input  fetch_fault
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Desc     : Instruction fetch: PC, IF/ID register, stall/redirect, fault flag.
//            FETCH_PERF_EN adds fetch and stall performance counters.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  wire           clk,
    input  wire           rst_n,
    fetch_stage_if.master bus
);

    // Widened so a full 4 GiB memory depth cannot overflow the limit
    localparam logic [33:0] c_IMEM_BYTES = 34'(IMEM_WORDS) * 34'd4;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic        r_fetch_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_redirect_misaligned;
    logic        w_in_range;
    logic        w_advance;

    assign w_pc_plus4            = r_pc + 32'd4;
    assign w_redirect_pc         = {bus.redirect_target[31:2], 2'b00};
    assign w_redirect_misaligned = (bus.redirect_target[1:0] != 2'b00);
    assign w_in_range            = ({2'b00, r_pc} < c_IMEM_BYTES);
    assign w_advance             = !bus.redirect && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= 32'h0000_0000;
            r_ifid_pc       <= 32'h0000_0000;
            r_ifid_pc_plus4 <= 32'h0000_0000;
            r_ifid_valid    <= 1'b0;
            r_fetch_fault   <= 1'b0;
        end else if (bus.redirect) begin
            // Squash keeps the old ifid_pc/pc_plus4; only instr/valid are cleared
            r_pc         <= w_redirect_pc;
            r_ifid_instr <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
            if (w_redirect_misaligned) begin
                r_fetch_fault <= 1'b1;
            end
        end else if (!bus.stall) begin
            r_pc            <= w_pc_plus4;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
            if (w_in_range) begin
                r_ifid_instr <= bus.imem_data;
                r_ifid_valid <= 1'b1;
            end else begin
                r_ifid_instr  <= 32'h0000_0000;
                r_ifid_valid  <= 1'b0;
                r_fetch_fault <= 1'b1;
            end
        end
    end

    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc       = r_ifid_pc;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.fetch_fault   = r_fetch_fault;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= 32'h0000_0000;
            r_perf_stall_cnt <= 32'h0000_0000;
        end else begin
            if (w_advance && w_in_range) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (bus.stall && !bus.redirect) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = r_perf_fetch_cnt;
    assign bus.perf_stall_cnt = r_perf_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_advance;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Desc     : Directed plus randomized check of fetch_stage against a reference
//            model; FETCH_PERF_EN also checks the performance counters.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int unsigned c_WORDS = 32;   // limit byte address 0x80

    logic clk;
    logic rst_n;
    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (c_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory beyond the populated depth still returns data; the DUT must ignore it
    logic [31:0] mem [256];
    assign bus.imem_data = mem[bus.imem_addr[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fcnt, m_scnt;
    logic        m_valid, m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"},     bus.imem_addr,           m_pc);
        chk({tag, ".ifid_instr"},    bus.ifid_instr,          m_instr);
        chk({tag, ".ifid_pc"},       bus.ifid_pc,             m_ipc);
        chk({tag, ".ifid_pc_plus4"}, bus.ifid_pc_plus4,       m_ipc4);
        chk({tag, ".ifid_valid"},    32'(bus.ifid_valid),     32'(m_valid));
        chk({tag, ".fetch_fault"},   32'(bus.fetch_fault),    32'(m_fault));
`ifdef FETCH_PERF_EN
        chk({tag, ".perf_fetch"},    bus.perf_fetch_cnt,      m_fcnt);
        chk({tag, ".perf_stall"},    bus.perf_stall_cnt,      m_scnt);
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    // One clock edge of the architectural behaviour
    task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
        if (rd) begin
            if (tgt % 4 != 0) m_fault = 1'b1;
            m_pc    = tgt - (tgt % 4);
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (st) begin
            m_scnt = m_scnt + 1;
        end else begin
            m_ipc  = m_pc;
            m_ipc4 = m_pc + 4;
            if (longint'(m_pc) < longint'(c_WORDS) * 4) begin
                m_instr = mem[(m_pc / 4) % 256];
                m_valid = 1'b1;
                m_fcnt  = m_fcnt + 1;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_fault = 1'b1;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input string tag);
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        model_edge(st, rd, tgt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset between edges with hostile control inputs
    task automatic mid_reset(input string tag);
        bus.stall           = 1'b1;
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h0000_0101;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        rst_n        = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        logic        st, rd;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        rst_n = 1'b0;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from reset
        step(0, 0, 0, "seq1"); chk("seq1_instr", bus.ifid_instr, 32'h11);
        step(0, 0, 0, "seq2"); chk("seq2_instr", bus.ifid_instr, 32'h22);
        step(0, 0, 0, "seq3"); chk("seq3_pc",    bus.ifid_pc,    32'h8);

        // Stall three cycles while ifid_pc = 8
        for (int i = 0; i < 3; i++) step(1, 0, 0, "stall");
        chk("stall_addr", bus.imem_addr, 32'hC);
        chk("stall_ipc",  bus.ifid_pc,   32'h8);
`ifdef FETCH_PERF_EN
        chk("stall_cnt",  bus.perf_stall_cnt, 32'd3);
`endif
        step(0, 0, 0, "release"); chk("release_pc", bus.ifid_pc, 32'hC);
        chk("release_instr", bus.ifid_instr, 32'h44);

        // Redirect wins over stall
        step(1, 1, 32'h40, "rdst");
        chk("rdst_addr",  bus.imem_addr,  32'h40);
        chk("rdst_valid", 32'(bus.ifid_valid), 32'd0);
        chk("rdst_instr", bus.ifid_instr, 32'h0);
        step(0, 0, 0, "rdtgt");
        chk("rdtgt_pc",    bus.ifid_pc,    32'h40);
        chk("rdtgt_valid", 32'(bus.ifid_valid), 32'd1);

        // Run to ifid_pc = 0x20, then reset asynchronously
        step(0, 1, 32'h18, "to18");
        for (int i = 0; i < 3; i++) step(0, 0, 0, "run20");
        chk("run20_pc", bus.ifid_pc, 32'h20);
        mid_reset("mreset");
        chk("mreset_addr",  bus.imem_addr,  32'h0);
        chk("mreset_valid", 32'(bus.ifid_valid), 32'd0);

        // Memory boundary: 0x7C last valid, 0x80 faults and still advances
        step(0, 1, 32'h74, "to74");
        for (int i = 0; i < 3; i++) step(0, 0, 0, "run7c");
        chk("last_valid", 32'(bus.ifid_valid),  32'd1);
        chk("last_fault", 32'(bus.fetch_fault), 32'd0);
        step(0, 0, 0, "oor");
        chk("oor_valid", 32'(bus.ifid_valid),  32'd0);
        chk("oor_fault", 32'(bus.fetch_fault), 32'd1);
        chk("oor_addr",  bus.imem_addr,        32'h84);

        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, "towrap");
        step(0, 0, 0, "wrap");
        chk("wrap_addr", bus.imem_addr,     32'h0);
        chk("wrap_pc4",  bus.ifid_pc_plus4, 32'h0);
        mid_reset("wreset");

        // Misaligned redirect is sticky until reset
        step(0, 1, 32'h42, "mis");
        chk("mis_addr",  bus.imem_addr, 32'h40);
        chk("mis_fault", 32'(bus.fetch_fault), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "mis_hold");
        chk("mis_sticky", 32'(bus.fetch_fault), 32'd1);
        mid_reset("mis_reset");
        chk("mis_cleared", 32'(bus.fetch_fault), 32'd0);

        // Randomized traffic with periodic resets
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom_range(0, 32'h9F);
                1:       tgt = 32'hFFFF_FFF8;
                2:       tgt = 32'h70 + 4 * $urandom_range(0, 7);
                default: tgt = 4 * $urandom_range(0, 32'h27);
            endcase
            step(st, rd, tgt, "rand");
            if (n % 80 == 79) mid_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
